// File: rtl/demux_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// demux_deserializer_pkg
// Shared definitions for the serial-to-parallel receive path.
//
// Contents:
//   DEFAULT_N : default parallel word width / number of demux slots.
//
// Optional build macro used by the files importing this package:
//   DEMUX_DESERIALIZER_MSB_FIRST_EN - first received bit lands in the MSB.
// ---------------------------------------------------------------------------
package demux_deserializer_pkg;

  // Word width used when the parent does not override N; must be a power
  // of two so the slot counter wraps naturally.
  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/demux_deserializer_decoder_n.sv
// ---------------------------------------------------------------------------
// decoder_n
// Generic 1:N one-hot decoder, the demux counterpart of an N:1 mux. In the
// deserializer it produces the per-bit write enables of the assembly
// register.
//
// Parameters:
//   N : number of outputs (power of two, N >= 2)
//   S : select width, $clog2(N), derived
//
// Ports:
//   sel    in  [S-1:0] index of the output to assert
//   en     in  1       global enable; all outputs low when 0
//   onehot out [N-1:0] one-hot decode of sel, or all zeros
// ---------------------------------------------------------------------------
module decoder_n
  import demux_deserializer_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int S = $clog2(N)
) (
  input  logic [S-1:0] sel,
  input  logic         en,
  output logic [N-1:0] onehot
);

  // Each output compares the select against its own index, gated by en.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (sel == S'(i));
    end
  end

endmodule

// File: rtl/demux_deserializer.sv
// ---------------------------------------------------------------------------
// demux_deserializer
// Receive end of an N:1 mux-tree serializer. One serial bit is accepted per
// handshake and steered into an assembly register slot chosen by an
// internal slot counter through a 1:N one-hot decoder. A completed word is
// copied into a holding register presented with valid/ready, so the next
// word can assemble while the previous one waits for the consumer.
//
// Parameters:
//   N : output word width / number of slots (power of two, N >= 2)
//   S : slot index width, $clog2(N), derived
//
// Ports:
//   clk       in  1       sole clock, rising edge
//   rst       in  1       synchronous active-high reset
//   in_bit    in  1       serial data bit
//   in_valid  in  1       in_bit is valid this cycle
//   in_ready  out 1       in_bit is accepted this cycle
//   out_data  out [N-1:0] completed parallel word
//   out_valid out 1       out_data holds an unconsumed word
//   out_ready in  1       consumer takes out_data this cycle
//   slot      out [S-1:0] slot the next accepted bit lands in
//
// Build options:
//   DEMUX_DESERIALIZER_MSB_FIRST_EN - when defined, the bit accepted at slot
//   k is written to position N-1-k (first bit ends up in out_data[N-1]).
//   Slot counting, completion and stall behaviour are identical either way.
// ---------------------------------------------------------------------------
module demux_deserializer
  import demux_deserializer_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [S-1:0] slot
);

  localparam logic [S-1:0] LAST_SLOT = S'(N - 1);

  logic [S-1:0] slot_q;
  logic [N-1:0] assembly_q;
  logic [N-1:0] assembly_next;
  logic [N-1:0] out_data_q;
  logic         out_valid_q;
  logic [S-1:0] wr_pos;
  logic [N-1:0] wr_en;
  logic         last_slot;
  logic         fire_in;
  logic         fire_out;
  logic         complete;

  assign last_slot = (slot_q == LAST_SLOT);

  // Only the word-completing bit can stall: it would overwrite the holding
  // register while it still holds a word nobody is taking this cycle.
  assign in_ready = !(last_slot && out_valid_q && !out_ready);

  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid_q && out_ready;
  assign complete = fire_in && last_slot;

`ifdef DEMUX_DESERIALIZER_MSB_FIRST_EN
  assign wr_pos = LAST_SLOT - slot_q;
`else
  assign wr_pos = slot_q;
`endif

  decoder_n #(
    .N (N)
  ) u_decoder (
    .sel    (wr_pos),
    .en     (fire_in),
    .onehot (wr_en)
  );

  // Assembly contents including the bit being written this cycle; this is
  // what gets handed to the holding register when the word completes, so
  // the last bit does not need an extra cycle to settle.
  assign assembly_next = (assembly_q & ~wr_en) | ({N{in_bit}} & wr_en);

  // Slot counter, assembly register and holding register. Completion wins
  // over consumption so a simultaneous load/unload keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      assembly_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (fire_in) begin
        assembly_q <= assembly_next;
        slot_q     <= last_slot ? '0 : slot_q + S'(1);
      end
      if (complete) begin
        out_data_q  <= assembly_next;
        out_valid_q <= 1'b1;
      end else if (fire_out) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;

endmodule
